fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Control FSM that drives the instruction-fetch stage's PC_WE, PC_reset, PC_Src and offset inputs, and watches the fetched instruction word.
- Boots the PC to 0 and steps it every cycle. Applies branch redirects and holds the PC under stall, deferring any branch that arrives during a stall.
- Stops on a HALT opcode or when a fetch-count watchdog expires.
- Sits between the decode/execute control logic and the fetch stage.

Parameters:
HALT_OPCODE, 6'h3F, value of instruction[31:26] that stops fetching
MAX_FETCH, 1024, number of PC advances after which fetching stops with timeout
CNT_W, 16, width of fetch_count; must satisfy MAX_FETCH < 2**CNT_W

Ports:
clk  in  1  single clock; all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  begin or restart execution; honoured only in IDLE or HALT
stall  in  1  hold current PC (downstream not ready)
branch_taken  in  1  redirect requested this cycle
branch_offset  in  16  signed word offset relative to current PC, paired with branch_taken
instruction  in  32  word currently output by the fetch stage
PC_WE  out  1  PC write enable to fetch stage
PC_reset  out  1  PC clear to fetch stage
PC_Src  out  1  0 = PC+4, 1 = PC+sext(offset)*4
offset  out  16  branch offset to fetch stage
instr_valid  out  1  instruction is valid this cycle
halted  out  1  sequencer stopped (HALT state)
timeout  out  1  stop was caused by the watchdog
fetch_count  out  CNT_W  number of PC advances since the last start

Behaviour:
- States: IDLE, INIT, RUN, STALL, HALT.
- Registered state: state, pend_v, pend_off[15:0], fetch_count, timeout.
- Reset (reset_n low, asynchronous): state=IDLE, pend_v=0, pend_off=0, fetch_count=0, timeout=0. Applies mid-operation as well; no PC write is issued while reset_n is low.
- Outputs are combinational from state, pending registers and inputs, so the fetch stage samples them on the same edge.
- Default output values: PC_WE=0, PC_reset=0, PC_Src=0, offset=0, instr_valid=0. halted=1 only in HALT.
- IDLE: all control outputs 0. start -> INIT.
- INIT: PC_reset=1 for exactly one cycle. On that edge fetch_count, timeout and pend_v clear. Next state RUN.
- RUN: instr_valid=1. Priority order, highest first:
  1. instruction[31:26]==HALT_OPCODE -> PC_WE=0, next HALT, timeout stays 0. The halt instruction is not stepped past.
  2. stall=1 -> PC_WE=0, next STALL. If branch_taken=1: pend_v<=1, pend_off<=branch_offset.
  3. Otherwise: PC_WE=1, PC_Src=branch_taken, offset=branch_taken?branch_offset:0, fetch_count<=fetch_count+1. If fetch_count+1==MAX_FETCH: next HALT, timeout<=1. Otherwise stay in RUN.
- STALL: instr_valid=0, PC_WE=0.
  - While stall=1: branch_taken=1 overwrites pend_off and sets pend_v (newest branch wins).
  - When stall=0: PC_WE=1, PC_Src=pend_v, offset=pend_v?pend_off:0, pend_v<=0, fetch_count increments, next RUN. The watchdog check is the same as in RUN.
  - branch_taken in the release cycle is ignored; the pending value is used.
  - The HALT opcode is not checked in STALL; it is seen on return to RUN.
- HALT: halted=1, PC_WE=0. fetch_count and timeout hold. start -> INIT.
- start is ignored in INIT, RUN and STALL.
- offset is passed through unmodified; sign extension and the ×4 scaling are done by the fetch stage.
- fetch_count never exceeds MAX_FETCH and never wraps.

Test Plan:
- Boot: reset_n low then high, start pulse for 1 cycle -> PC_reset=1 for exactly 1 cycle, then PC_WE=1 each cycle. After 5 RUN cycles fetch_count=5 and the fetch stage PC=20.
- Branch: in RUN, branch_taken=1 with branch_offset=16'hFFFE at PC=40 -> PC_Src=1, offset=FFFE on that cycle, next PC=32.
- Stalled branch: stall=1 for 3 cycles with branch_taken pulsed, offset 3 then 5 -> PC_WE=0 and instr_valid=0 during the stall. On release PC_Src=1, offset=5, PC advances by 20, pend_v clears.
- Halt: memory word 2 has opcode 6'h3F -> PC stops at 8, halted=1, timeout=0, fetch_count=2. A start pulse restarts from PC=0 with fetch_count=0.
- Watchdog: MAX_FETCH=4, no halt opcode -> after 4 advances halted=1, timeout=1, fetch_count=4, no further PC_WE.
- Async reset mid-STALL with pend_v=1 -> state IDLE immediately, all outputs 0. After start, the first advance uses PC_Src=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: boots the PC, steps it, applies branch redirects,
// holds under stall (deferring branches), and stops on HALT opcode or watchdog.
module fetch_sequencer #(
    parameter logic [5:0]  HALT_OPCODE = 6'h3F,
    parameter int unsigned MAX_FETCH   = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [15:0]      branch_offset,
    input  logic [31:0]      instruction,
    output logic             PC_WE,
    output logic             PC_reset,
    output logic             PC_Src,
    output logic [15:0]      offset,
    output logic             instr_valid,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_STALL = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_pend_v;
    logic [15:0]        r_pend_off;
    logic [CNT_W-1:0]   r_fetch_count;
    logic               r_timeout;

    state_t             w_state_nxt;
    logic               w_pend_v_nxt;
    logic [15:0]        w_pend_off_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_timeout_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_cnt_limit;
    logic               w_is_halt;

    // Only the opcode field is inspected.
    logic w_unused;
    assign w_unused = &{1'b0, instruction[25:0]};

    assign w_cnt_inc   = r_fetch_count + CNT_W'(1);
    assign w_cnt_limit = (w_cnt_inc == CNT_W'(MAX_FETCH));
    assign w_is_halt   = (instruction[31:26] == HALT_OPCODE);

    assign fetch_count = r_fetch_count;
    assign timeout     = r_timeout;

    // Next-state and same-cycle control outputs for the fetch stage.
    always_comb begin
        w_state_nxt    = r_state;
        w_pend_v_nxt   = r_pend_v;
        w_pend_off_nxt = r_pend_off;
        w_cnt_nxt      = r_fetch_count;
        w_timeout_nxt  = r_timeout;
        PC_WE          = 1'b0;
        PC_reset       = 1'b0;
        PC_Src         = 1'b0;
        offset         = 16'h0000;
        instr_valid    = 1'b0;
        halted         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_INIT;
            end
            S_INIT: begin
                PC_reset      = 1'b1;
                w_cnt_nxt     = '0;
                w_timeout_nxt = 1'b0;
                w_pend_v_nxt  = 1'b0;
                w_state_nxt   = S_RUN;
            end
            S_RUN: begin
                instr_valid = 1'b1;
                if (w_is_halt) begin
                    w_state_nxt = S_HALT;
                end else if (stall) begin
                    w_state_nxt = S_STALL;
                    if (branch_taken) begin
                        w_pend_v_nxt   = 1'b1;
                        w_pend_off_nxt = branch_offset;
                    end
                end else begin
                    PC_WE     = 1'b1;
                    PC_Src    = branch_taken;
                    offset    = branch_taken ? branch_offset : 16'h0000;
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_limit) begin
                        w_state_nxt   = S_HALT;
                        w_timeout_nxt = 1'b1;
                    end
                end
            end
            S_STALL: begin
                if (stall) begin
                    // Newest branch seen during the stall wins.
                    if (branch_taken) begin
                        w_pend_v_nxt   = 1'b1;
                        w_pend_off_nxt = branch_offset;
                    end
                end else begin
                    PC_WE        = 1'b1;
                    PC_Src       = r_pend_v;
                    offset       = r_pend_v ? r_pend_off : 16'h0000;
                    w_pend_v_nxt = 1'b0;
                    w_cnt_nxt    = w_cnt_inc;
                    if (w_cnt_limit) begin
                        w_state_nxt   = S_HALT;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) w_state_nxt = S_INIT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_pend_v      <= 1'b0;
            r_pend_off    <= 16'h0000;
            r_fetch_count <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pend_v      <= w_pend_v_nxt;
            r_pend_off    <= w_pend_off_nxt;
            r_fetch_count <= w_cnt_nxt;
            r_timeout     <= w_timeout_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural fetch-stage PC and instruction memory.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, stall, branch_taken;
    logic [15:0] branch_offset;
    logic [31:0] instruction;
    logic        PC_WE, PC_reset, PC_Src, instr_valid, halted, timeout;
    logic [15:0] offset;
    logic [15:0] fetch_count;

    logic        wd_start, wd_stall, wd_branch;
    logic [15:0] wd_boff;
    logic [31:0] wd_instr;
    logic        wd_PC_WE, wd_PC_reset, wd_PC_Src, wd_instr_valid, wd_halted, wd_timeout;
    logic [15:0] wd_offset;
    logic [15:0] wd_fetch_count;

    logic [31:0] mem [0:63];
    logic [31:0] pc  = 32'h0;
    logic [31:0] wpc = 32'h0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .instruction(instruction), .PC_WE(PC_WE), .PC_reset(PC_reset),
        .PC_Src(PC_Src), .offset(offset), .instr_valid(instr_valid),
        .halted(halted), .timeout(timeout), .fetch_count(fetch_count)
    );

    fetch_sequencer #(.MAX_FETCH(4)) wd (
        .clk(clk), .reset_n(reset_n), .start(wd_start), .stall(wd_stall),
        .branch_taken(wd_branch), .branch_offset(wd_boff),
        .instruction(wd_instr), .PC_WE(wd_PC_WE), .PC_reset(wd_PC_reset),
        .PC_Src(wd_PC_Src), .offset(wd_offset), .instr_valid(wd_instr_valid),
        .halted(wd_halted), .timeout(wd_timeout), .fetch_count(wd_fetch_count)
    );

    assign instruction = mem[pc[7:2]];

    // Fetch-stage PC models: clear, PC+4, or PC + sext(offset)*4.
    always @(posedge clk) begin
        if (PC_reset)   pc <= 32'h0;
        else if (PC_WE) pc <= PC_Src ? pc + {{14{offset[15]}}, offset, 2'b00} : pc + 32'd4;
        if (wd_PC_reset)   wpc <= 32'h0;
        else if (wd_PC_WE) wpc <= wd_PC_Src ? wpc + {{14{wd_offset[15]}}, wd_offset, 2'b00} : wpc + 32'd4;
    end

    // Control vector order: {PC_WE, PC_reset, PC_Src, instr_valid, halted}
    function automatic logic [4:0] ctrl();
        return {PC_WE, PC_reset, PC_Src, instr_valid, halted};
    endfunction

    function automatic logic [4:0] wctrl();
        return {wd_PC_WE, wd_PC_reset, wd_PC_Src, wd_instr_valid, wd_halted};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0; start = 1'b1;
        #1;
        checks++;
        if ({ctrl(), offset, timeout, fetch_count} !== 38'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ctrl=%b off=%h to=%b cnt=%0d, want all 0", ctrl(), offset, timeout, fetch_count);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ctrl() !== 5'b00000) begin
            errors++;
            $display("FAIL reset_holds_idle: got ctrl=%b want 00000", ctrl());
        end
        reset_n = 1'b1; start = 1'b0;
    endtask

    task automatic test_boot();
        @(negedge clk);
        start = 1'b1;
        #1;
        checks++;
        if (ctrl() !== 5'b00000) begin
            errors++;
            $display("FAIL boot_idle: got ctrl=%b want 00000", ctrl());
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (ctrl() !== 5'b01000) begin
            errors++;
            $display("FAIL boot_init: got ctrl=%b want 01000", ctrl());
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (ctrl() !== 5'b10010 || fetch_count !== 16'(i) || pc !== 32'(4 * i)) begin
                errors++;
                $display("FAIL boot_step%0d: got ctrl=%b cnt=%0d pc=%0d want 10010 cnt=%0d pc=%0d", i, ctrl(), fetch_count, pc, i, 4 * i);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (fetch_count !== 16'd5 || pc !== 32'd20) begin
            errors++;
            $display("FAIL boot_after5: got cnt=%0d pc=%0d want cnt=5 pc=20", fetch_count, pc);
        end
    endtask

    task automatic test_branch();
        start = 1'b1;
        #1;
        checks++;
        if (PC_reset !== 1'b0 || PC_WE !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored_run: got PC_reset=%b PC_WE=%b want 0 1", PC_reset, PC_WE);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (pc !== 32'd40 || fetch_count !== 16'd10) begin
            errors++;
            $display("FAIL branch_pre: got pc=%0d cnt=%0d want 40 10", pc, fetch_count);
        end
        branch_taken = 1'b1; branch_offset = 16'hFFFE;
        #1;
        checks++;
        if (ctrl() !== 5'b10110 || offset !== 16'hFFFE) begin
            errors++;
            $display("FAIL branch_ctrl: got ctrl=%b off=%h want 10110 FFFE", ctrl(), offset);
        end
        @(negedge clk);
        branch_taken = 1'b0; branch_offset = 16'h0;
        #1;
        checks++;
        if (pc !== 32'd32 || fetch_count !== 16'd11) begin
            errors++;
            $display("FAIL branch_target: got pc=%0d cnt=%0d want 32 11", pc, fetch_count);
        end
    endtask

    task automatic test_stall_branch();
        stall = 1'b1; branch_taken = 1'b1; branch_offset = 16'd3;
        #1;
        checks++;
        if (ctrl() !== 5'b00010) begin
            errors++;
            $display("FAIL stall_enter: got ctrl=%b want 00010", ctrl());
        end
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        checks++;
        if (ctrl() !== 5'b00000 || pc !== 32'd32) begin
            errors++;
            $display("FAIL stall_hold1: got ctrl=%b pc=%0d want 00000 32", ctrl(), pc);
        end
        @(negedge clk);
        branch_taken = 1'b1; branch_offset = 16'd5;
        #1;
        checks++;
        if (ctrl() !== 5'b00000) begin
            errors++;
            $display("FAIL stall_hold2: got ctrl=%b want 00000", ctrl());
        end
        @(negedge clk);
        stall = 1'b0; branch_taken = 1'b1; branch_offset = 16'd7;
        #1;
        checks++;
        if (ctrl() !== 5'b10100 || offset !== 16'd5) begin
            errors++;
            $display("FAIL stall_release: got ctrl=%b off=%h want 10100 0005", ctrl(), offset);
        end
        @(negedge clk);
        branch_taken = 1'b0; branch_offset = 16'h0;
        #1;
        checks++;
        if (pc !== 32'd52 || fetch_count !== 16'd12 || ctrl() !== 5'b10010) begin
            errors++;
            $display("FAIL stall_target: got pc=%0d cnt=%0d ctrl=%b want 52 12 10010", pc, fetch_count, ctrl());
        end
        stall = 1'b1;
        @(negedge clk);
        stall = 1'b0;
        #1;
        checks++;
        if (ctrl() !== 5'b10000 || offset !== 16'h0) begin
            errors++;
            $display("FAIL pend_cleared: got ctrl=%b off=%h want 10000 0000", ctrl(), offset);
        end
        @(negedge clk);
        #1;
        checks++;
        if (pc !== 32'd56 || fetch_count !== 16'd13) begin
            errors++;
            $display("FAIL plain_release: got pc=%0d cnt=%0d want 56 13", pc, fetch_count);
        end
    endtask

    task automatic test_halt();
        @(negedge clk);
        reset_n = 1'b0; mem[2] = 32'hFC00_0000;
        @(negedge clk);
        reset_n = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (ctrl() !== 5'b00010 || pc !== 32'd8) begin
            errors++;
            $display("FAIL halt_seen: got ctrl=%b pc=%0d want 00010 8", ctrl(), pc);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (ctrl() !== 5'b00001 || timeout !== 1'b0 || fetch_count !== 16'd2 || pc !== 32'd8) begin
            errors++;
            $display("FAIL halt_state: got ctrl=%b to=%b cnt=%0d pc=%0d want 00001 0 2 8", ctrl(), timeout, fetch_count, pc);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (ctrl() !== 5'b01000 || fetch_count !== 16'd2) begin
            errors++;
            $display("FAIL halt_restart_init: got ctrl=%b cnt=%0d want 01000 2", ctrl(), fetch_count);
        end
        @(negedge clk);
        #1;
        checks++;
        if (pc !== 32'd0 || fetch_count !== 16'd0 || ctrl() !== 5'b10010) begin
            errors++;
            $display("FAIL halt_restart_run: got pc=%0d cnt=%0d ctrl=%b want 0 0 10010", pc, fetch_count, ctrl());
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        reset_n = 1'b0; mem[2] = 32'h0;
        @(negedge clk);
        reset_n = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        stall = 1'b1; branch_taken = 1'b1; branch_offset = 16'd9;
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        checks++;
        if (ctrl() !== 5'b00000) begin
            errors++;
            $display("FAIL ar_in_stall: got ctrl=%b want 00000", ctrl());
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ctrl(), offset, timeout, fetch_count} !== 38'h0) begin
            errors++;
            $display("FAIL ar_immediate: got ctrl=%b off=%h to=%b cnt=%0d want all 0", ctrl(), offset, timeout, fetch_count);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (PC_WE !== 1'b0) begin
            errors++;
            $display("FAIL ar_no_we: got PC_WE=%b want 0", PC_WE);
        end
        @(negedge clk);
        reset_n = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (ctrl() !== 5'b01000) begin
            errors++;
            $display("FAIL ar_init: got ctrl=%b want 01000", ctrl());
        end
        @(negedge clk);
        #1;
        checks++;
        if (ctrl() !== 5'b10010 || offset !== 16'h0 || fetch_count !== 16'd0) begin
            errors++;
            $display("FAIL ar_first_step: got ctrl=%b off=%h cnt=%0d want 10010 0000 0", ctrl(), offset, fetch_count);
        end
    endtask

    task automatic test_watchdog();
        @(negedge clk);
        wd_start = 1'b1;
        @(negedge clk);
        wd_start = 1'b0;
        #1;
        checks++;
        if (wctrl() !== 5'b01000) begin
            errors++;
            $display("FAIL wd_init: got ctrl=%b want 01000", wctrl());
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (wctrl() !== 5'b10010 || wd_fetch_count !== 16'(i)) begin
                errors++;
                $display("FAIL wd_step%0d: got ctrl=%b cnt=%0d want 10010 %0d", i, wctrl(), wd_fetch_count, i);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (wctrl() !== 5'b00001 || wd_timeout !== 1'b1 || wd_fetch_count !== 16'd4 || wpc !== 32'd16) begin
            errors++;
            $display("FAIL wd_expire: got ctrl=%b to=%b cnt=%0d pc=%0d want 00001 1 4 16", wctrl(), wd_timeout, wd_fetch_count, wpc);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (wd_PC_WE !== 1'b0 || wpc !== 32'd16 || wd_fetch_count !== 16'd4) begin
            errors++;
            $display("FAIL wd_hold: got we=%b pc=%0d cnt=%0d want 0 16 4", wd_PC_WE, wpc, wd_fetch_count);
        end
        wd_start = 1'b1;
        @(negedge clk);
        wd_start = 1'b0;
        #1;
        checks++;
        if (wctrl() !== 5'b01000 || wd_timeout !== 1'b1) begin
            errors++;
            $display("FAIL wd_restart_init: got ctrl=%b to=%b want 01000 1", wctrl(), wd_timeout);
        end
        @(negedge clk);
        #1;
        checks++;
        if (wd_timeout !== 1'b0 || wd_fetch_count !== 16'd0 || wpc !== 32'd0) begin
            errors++;
            $display("FAIL wd_restart_clear: got to=%b cnt=%0d pc=%0d want 0 0 0", wd_timeout, wd_fetch_count, wpc);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        reset_n = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_offset = 16'h0;
        wd_start = 1'b0; wd_stall = 1'b0; wd_branch = 1'b0; wd_boff = 16'h0; wd_instr = 32'h0;
        test_reset();
        test_boot();
        test_branch();
        test_stall_branch();
        test_halt();
        test_async_reset();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
